btn_hold_detect: RTL and testbench

- Upstream conditioning stage for the raw push-button/reset input that drives the LED blink-rate logic.
- Synchronises the asynchronous pin, debounces press and release, and measures hold time.
- Produces a clean level, one-cycle press/release pulses, and a long-hold indication (button held ≥ HOLD_CYCLES).
- Downstream blink logic uses long_hold to select the fast-blink counter bit, instead of the raw pin.

---
 rtl/btn_hold_detect.sv | 223 ++++++++++++++++++++++
 tb/tb_btn_hold_detect.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_hold_detect.sv
`default_nettype none
// ============================================================================
//  Module      : btn_hold_detect
//  Description : Conditioning stage for a raw push-button input. Synchronises
//                the pin, debounces press and release, measures how long the
//                press lasts and reports a clean level, one-cycle press /
//                release pulses and a long-hold indication.
//  Revision    : 1.0 - initial release
// ============================================================================
module btn_hold_detect #(
    parameter int DEBOUNCE_CYCLES = 2500000,
    parameter int HOLD_CYCLES     = 125000000,
    parameter int CNT_W           = 32
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_in,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_hold,
    output logic long_pulse
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [2:0] c_ST_IDLE         = 3'd0;
    localparam logic [2:0] c_ST_PRESS_WAIT   = 3'd1;
    localparam logic [2:0] c_ST_PRESSED      = 3'd2;
    localparam logic [2:0] c_ST_HELD         = 3'd3;
    localparam logic [2:0] c_ST_RELEASE_WAIT = 3'd4;

    // Counter terminal values. The hold counter stops one short of
    // HOLD_CYCLES because it is cleared on the press edge itself.
    localparam logic [CNT_W-1:0] c_DEB_LIMIT = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] c_HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] c_CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------------
    logic             r_sync1;
    logic             r_btn_s;
    logic [2:0]       r_state;
    logic             r_ret_held;     // RELEASE_WAIT returns to HELD when set
    logic [CNT_W-1:0] r_dcnt;
    logic [CNT_W-1:0] r_hcnt;
    logic             r_btn_level;
    logic             r_long_hold;
    logic             r_press_pulse;
    logic             r_release_pulse;
    logic             r_long_pulse;

    // ------------------------------------------------------------------------
    // Next-state values
    // ------------------------------------------------------------------------
    logic [2:0]       w_state_nxt;
    logic             w_ret_held_nxt;
    logic [CNT_W-1:0] w_dcnt_nxt;
    logic [CNT_W-1:0] w_hcnt_nxt;
    logic             w_level_nxt;
    logic             w_long_nxt;
    logic             w_press_nxt;
    logic             w_release_nxt;
    logic             w_longp_nxt;

    logic             w_deb_done;
    logic             w_hold_done;

    assign w_deb_done  = (r_dcnt == c_DEB_LIMIT);
    assign w_hold_done = (r_hcnt == c_HOLD_LAST);

    // Two-flop synchroniser for the asynchronous button pin.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 1'b0;
            r_btn_s <= 1'b0;
        end else begin
            r_sync1 <= btn_in;
            r_btn_s <= r_sync1;
        end
    end

    // Debounce / hold-time FSM: computes every next value; pulses default low.
    always_comb begin
        w_state_nxt    = r_state;
        w_ret_held_nxt = r_ret_held;
        w_dcnt_nxt     = r_dcnt;
        w_hcnt_nxt     = r_hcnt;
        w_level_nxt    = r_btn_level;
        w_long_nxt     = r_long_hold;
        w_press_nxt    = 1'b0;
        w_release_nxt  = 1'b0;
        w_longp_nxt    = 1'b0;

        case (r_state)
            c_ST_IDLE: begin
                if (r_btn_s) begin
                    w_state_nxt = c_ST_PRESS_WAIT;
                    w_dcnt_nxt  = c_CNT_ONE;
                end
            end

            c_ST_PRESS_WAIT: begin
                if (!r_btn_s) begin
                    // Glitch shorter than the debounce window: drop it.
                    w_state_nxt = c_ST_IDLE;
                    w_dcnt_nxt  = c_CNT_ZERO;
                end else if (w_deb_done) begin
                    w_state_nxt = c_ST_PRESSED;
                    w_dcnt_nxt  = c_CNT_ZERO;
                    w_hcnt_nxt  = c_CNT_ZERO;
                    w_level_nxt = 1'b1;
                    w_press_nxt = 1'b1;
                end else begin
                    w_dcnt_nxt = r_dcnt + c_CNT_ONE;
                end
            end

            c_ST_PRESSED: begin
                // Hold timing runs independently of any release bounce.
                if (w_hold_done) begin
                    w_long_nxt  = 1'b1;
                    w_longp_nxt = 1'b1;
                end else begin
                    w_hcnt_nxt = r_hcnt + c_CNT_ONE;
                end

                if (!r_btn_s) begin
                    w_state_nxt    = c_ST_RELEASE_WAIT;
                    w_dcnt_nxt     = c_CNT_ONE;
                    w_ret_held_nxt = w_hold_done;
                end else if (w_hold_done) begin
                    w_state_nxt = c_ST_HELD;
                end
            end

            c_ST_HELD: begin
                if (!r_btn_s) begin
                    w_state_nxt    = c_ST_RELEASE_WAIT;
                    w_dcnt_nxt     = c_CNT_ONE;
                    w_ret_held_nxt = 1'b1;
                end
            end

            c_ST_RELEASE_WAIT: begin
                if (!r_btn_s && w_deb_done) begin
                    // Release accepted; it takes priority over a same-cycle
                    // long-hold promotion so pulses stay exclusive.
                    w_state_nxt    = c_ST_IDLE;
                    w_dcnt_nxt     = c_CNT_ZERO;
                    w_hcnt_nxt     = c_CNT_ZERO;
                    w_ret_held_nxt = 1'b0;
                    w_level_nxt    = 1'b0;
                    w_long_nxt     = 1'b0;
                    w_release_nxt  = 1'b1;
                end else begin
                    if (!r_ret_held) begin
                        if (w_hold_done) begin
                            w_long_nxt     = 1'b1;
                            w_longp_nxt    = 1'b1;
                            w_ret_held_nxt = 1'b1;
                        end else begin
                            w_hcnt_nxt = r_hcnt + c_CNT_ONE;
                        end
                    end

                    if (r_btn_s) begin
                        // Bounce rejected: resume where the press left off.
                        w_dcnt_nxt  = c_CNT_ZERO;
                        w_state_nxt = w_ret_held_nxt ? c_ST_HELD : c_ST_PRESSED;
                    end else begin
                        w_dcnt_nxt = r_dcnt + c_CNT_ONE;
                    end
                end
            end

            default: begin
                w_state_nxt    = c_ST_IDLE;
                w_ret_held_nxt = 1'b0;
                w_dcnt_nxt     = c_CNT_ZERO;
                w_hcnt_nxt     = c_CNT_ZERO;
                w_level_nxt    = 1'b0;
                w_long_nxt     = 1'b0;
            end
        endcase
    end

    // FSM state, counters and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= c_ST_IDLE;
            r_ret_held      <= 1'b0;
            r_dcnt          <= c_CNT_ZERO;
            r_hcnt          <= c_CNT_ZERO;
            r_btn_level     <= 1'b0;
            r_long_hold     <= 1'b0;
            r_press_pulse   <= 1'b0;
            r_release_pulse <= 1'b0;
            r_long_pulse    <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_ret_held      <= w_ret_held_nxt;
            r_dcnt          <= w_dcnt_nxt;
            r_hcnt          <= w_hcnt_nxt;
            r_btn_level     <= w_level_nxt;
            r_long_hold     <= w_long_nxt;
            r_press_pulse   <= w_press_nxt;
            r_release_pulse <= w_release_nxt;
            r_long_pulse    <= w_longp_nxt;
        end
    end

    assign btn_level     = r_btn_level;
    assign press_pulse   = r_press_pulse;
    assign release_pulse = r_release_pulse;
    assign long_hold     = r_long_hold;
    assign long_pulse    = r_long_pulse;

endmodule
`default_nettype wire

// File: tb/tb_btn_hold_detect.sv
`default_nettype none
// ============================================================================
//  Module      : tb_btn_hold_detect
//  Description : Self-checking bench for btn_hold_detect. A run-length model
//                of debounce and hold time is compared every cycle; directed
//                scenarios pin exact latencies with literal values, followed
//                by randomized button activity with occasional resets.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_btn_hold_detect;

    localparam int DEB  = 4;
    localparam int HOLD = 20;

    logic clk;
    logic reset_n;
    logic btn_in;
    logic btn_level, press_pulse, release_pulse, long_hold, long_pulse;

    int total;
    int bad;
    int n_press, n_release, n_longp;

    btn_hold_detect #(
        .DEBOUNCE_CYCLES (DEB),
        .HOLD_CYCLES     (HOLD),
        .CNT_W           (8)
    ) u_dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .btn_in        (btn_in),
        .btn_level     (btn_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_hold     (long_hold),
        .long_pulse    (long_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // Reference model: the synchronised pin is btn_in delayed by two edges.
    // A level change is accepted on the (DEB+1)-th consecutive sample that
    // differs from the current level. Long hold fires HOLD edges after the
    // press was accepted unless the release is accepted first.
    // ------------------------------------------------------------------------
    logic [1:0] m_hist;
    int         m_run;
    int         m_age;
    logic       m_level, m_long, m_press, m_release, m_longp;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_hist = 2'b00; m_run = 0; m_age = 0;
            m_level = 0; m_long = 0; m_press = 0; m_release = 0; m_longp = 0;
        end else begin
            logic s;
            s = m_hist[1];
            m_hist = {m_hist[0], btn_in};
            m_press = 0; m_release = 0; m_longp = 0;
            m_run = (s != m_level) ? m_run + 1 : 0;
            if (m_run == DEB + 1) begin
                m_run = 0;
                m_level = s;
                if (s) begin
                    m_press = 1;
                    m_age = 0;
                end else begin
                    m_release = 1;
                    m_long = 0;
                end
            end else if (m_level && !m_long) begin
                m_age = m_age + 1;
                if (m_age == HOLD) begin
                    m_long = 1;
                    m_longp = 1;
                end
            end
        end
    end

    // Per-cycle comparison against the model, plus pulse exclusivity.
    always @(negedge clk) begin
        logic [4:0] act, exp;
        act = {btn_level, press_pulse, release_pulse, long_hold, long_pulse};
        exp = {m_level, m_press, m_release, m_long, m_longp};
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL cycle_compare t=%0t actual=%b required=%b", $time, act, exp);
        end
        total++;
        if ($countones({press_pulse, release_pulse, long_pulse}) > 1) begin
            bad++;
            $display("FAIL pulse_exclusive t=%0t actual=%b required=at most one",
                     $time, {press_pulse, release_pulse, long_pulse});
        end
        if (press_pulse   === 1'b1) n_press++;
        if (release_pulse === 1'b1) n_release++;
        if (long_pulse    === 1'b1) n_longp++;
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic int outs();
        return {27'd0, btn_level, press_pulse, release_pulse, long_hold, long_pulse};
    endfunction

    int p0, r0, l0;

    initial begin
        total = 0; bad = 0; n_press = 0; n_release = 0; n_longp = 0;
        reset_n = 1'b0;
        btn_in  = 1'b0;
        tick(3);
        check("reset_outputs", outs(), 0);
        reset_n = 1'b1;

        // Idle after reset: nothing moves.
        tick(50);
        check("idle_outputs", outs(), 0);
        check("idle_no_pulses", n_press + n_release + n_longp, 0);

        // Clean press. btn_in changes just after edge 0; edge 1 is the first
        // to sample it, so the level rises on edge DEB+3 (DEB+2 after that).
        btn_in = 1'b1;
        tick(DEB + 2);
        check("press_not_yet", btn_level, 0);
        tick();
        check("press_level", btn_level, 1);
        check("press_pulse", press_pulse, 1);
        check("model_level_pin", m_level, 1);
        tick();
        check("press_pulse_one_cycle", press_pulse, 0);
        tick(HOLD - 2);
        check("long_not_yet", long_hold, 0);
        tick();
        check("long_hold_rise", {long_hold, long_pulse}, 3);
        check("model_long_pin", m_long, 1);
        tick();
        check("long_pulse_one_cycle", {long_hold, long_pulse}, 2);
        tick(70);
        btn_in = 1'b0;
        tick(DEB + 2);
        check("release_not_yet", {btn_level, long_hold}, 3);
        tick();
        check("release_edge", outs(), 5'b00100);
        tick();
        check("release_done", outs(), 0);
        tick(10);

        // Glitches shorter than the debounce window.
        p0 = n_press;
        btn_in = 1'b1; tick(3);
        btn_in = 1'b0; tick(2);
        btn_in = 1'b1; tick(2);
        btn_in = 1'b0; tick(20);
        check("glitch_no_press", n_press - p0, 0);
        check("glitch_level", btn_level, 0);

        // Press with a 3-cycle release bounce 5 cycles after the level rise.
        p0 = n_press; r0 = n_release; l0 = n_longp;
        btn_in = 1'b1;
        tick(DEB + 3);
        check("bounce_press", btn_level, 1);
        tick(5);
        btn_in = 1'b0; tick(3);
        btn_in = 1'b1;
        tick(HOLD - 9);
        check("bounce_level_kept", {btn_level, long_hold}, 2);
        tick();
        check("bounce_long_on_time", {long_hold, long_pulse}, 3);
        tick(5);
        btn_in = 1'b0;
        tick(15);
        check("bounce_press_count", n_press - p0, 1);
        check("bounce_release_count", n_release - r0, 1);
        check("bounce_long_count", n_longp - l0, 1);

        // Short press: level high for 10 cycles, no long hold.
        p0 = n_press; r0 = n_release; l0 = n_longp;
        btn_in = 1'b1;
        tick(DEB + 3);
        tick(3);
        btn_in = 1'b0;
        tick(DEB + 2);
        check("short_level_still_high", btn_level, 1);
        tick();
        check("short_release", {btn_level, release_pulse}, 1);
        tick(10);
        check("short_counts", (n_press - p0) * 100 + (n_release - r0) * 10 + (n_longp - l0), 110);

        // Reset while HELD with the button still down.
        r0 = n_release;
        btn_in = 1'b1;
        tick(DEB + 3 + HOLD + 3);
        check("pre_reset_held", {btn_level, long_hold}, 3);
        reset_n = 1'b0;
        #2;
        check("reset_async_clear", outs(), 0);
        tick(3);
        check("reset_hold_clear", outs(), 0);
        reset_n = 1'b1;
        tick(DEB + 2);
        check("after_reset_not_yet", btn_level, 0);
        tick();
        check("after_reset_press", {btn_level, press_pulse}, 3);
        tick(HOLD);
        check("after_reset_long", {long_hold, long_pulse}, 3);
        check("no_release_on_reset", n_release - r0, 0);
        btn_in = 1'b0;
        tick(20);

        // Randomized activity with occasional mid-operation resets.
        for (int r = 0; r < 400; r++) begin
            btn_in = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 59) == 0) begin
                reset_n = 1'b0;
                tick();
                reset_n = 1'b1;
            end
            tick($urandom_range(1, 40));
        end
        btn_in = 1'b0;
        tick(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
